// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: drain FSM encoding and
// the default in-flight limit for long-latency writes.
package reg_scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_ACK   = 2'd2
  } sb_state_e;

  localparam int SB_MAX_OUTSTANDING_DEF = 4;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending long-latency writes, raises decode
// stalls for RAW/WAW/full hazards and drains all outstanding ops on request.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = SB_MAX_OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        uses_rs1,
  input  logic        uses_rs2,
  input  logic        wr_en_d,
  input  logic        long_op,
  input  logic        flush_exe,
  input  logic        wb_done,
  input  logic [4:0]  wb_rd,
  input  logic        drain_req,
  output logic        stall_id,
  output logic        drain_ack,
  output logic [31:0] busy_mask,
  output logic [3:0]  outstanding
);

  localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

  sb_state_e   state, state_nxt;
  logic        clr_hit, set_hit, accept;
  logic        raw_hit, waw_hit, full_hit, drain_hit;
  logic [31:0] clr_vec, set_vec, eff_busy;

  // A retiring register reads as free this cycle (decode write-through).
  // WAW uses the same view so a same-cycle reissue can win over the clear.
  assign clr_hit  = wb_done & (wb_rd != 5'd0) & busy_mask[wb_rd];
  assign clr_vec  = clr_hit ? (32'd1 << wb_rd) : 32'd0;
  assign eff_busy = busy_mask & ~clr_vec;

  assign raw_hit   = (uses_rs1 & (rs1_d != 5'd0) & eff_busy[rs1_d]) |
                     (uses_rs2 & (rs2_d != 5'd0) & eff_busy[rs2_d]);
  assign waw_hit   = long_op & wr_en_d & (rd_d != 5'd0) & eff_busy[rd_d];
  assign full_hit  = long_op & (outstanding == OUT_MAX) & ~clr_hit;
  assign drain_hit = (state != SB_IDLE);

  assign stall_id = issue_valid & (raw_hit | waw_hit | full_hit | drain_hit);
  assign accept   = issue_valid & ~stall_id & ~flush_exe;
  assign set_hit  = accept & long_op & wr_en_d & (rd_d != 5'd0);
  assign set_vec  = set_hit ? (32'd1 << rd_d) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask   <= 32'd0;
      outstanding <= 4'd0;
    end else begin
      busy_mask <= (busy_mask & ~clr_vec) | set_vec;
      case ({set_hit, clr_hit})
        2'b10:   if (outstanding != 4'hF) outstanding <= outstanding + 4'd1;
        2'b01:   if (outstanding != 4'h0) outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    drain_ack = 1'b0;
    case (state)
      SB_IDLE:  if (drain_req) state_nxt = SB_DRAIN;
      SB_DRAIN: if (outstanding == 4'd0) state_nxt = SB_ACK;
      SB_ACK: begin
        drain_ack = 1'b1;
        state_nxt = SB_IDLE;
      end
      default:  state_nxt = SB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus pushes hand-computed expected
// outputs per cycle; a negedge monitor pops and compares them.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, uses_rs1, uses_rs2, wr_en_d, long_op, flush_exe;
  logic        wb_done, drain_req;
  logic [4:0]  rs1_d, rs2_d, rd_d, wb_rd;
  logic        stall_id, drain_ack;
  logic [31:0] busy_mask;
  logic [3:0]  outstanding;

  typedef struct {
    string       name;
    int          cyc;
    logic        stall;
    logic [31:0] busy;
    logic [3:0]  outs;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 1'b0;

  reg_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .wr_en_d(wr_en_d),
    .long_op(long_op), .flush_exe(flush_exe), .wb_done(wb_done),
    .wb_rd(wb_rd), .drain_req(drain_req), .stall_id(stall_id),
    .drain_ack(drain_ack), .busy_mask(busy_mask), .outstanding(outstanding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid = 0; uses_rs1 = 0; uses_rs2 = 0; wr_en_d = 0; long_op = 0;
    flush_exe = 0; wb_done = 0; drain_req = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; wb_rd = 0;
  endtask

  task automatic iss_long(input logic [4:0] rd);
    issue_valid = 1; long_op = 1; wr_en_d = 1; rd_d = rd;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_done = 1; wb_rd = r;
  endtask

  task automatic chk(input string name, input logic st, input logic [31:0] bm,
                     input logic [3:0] os, input logic ak);
    exp_t e;
    e.name = name; e.cyc = cyc; e.stall = st; e.busy = bm; e.outs = os; e.ack = ak;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation registered for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (stall_id !== e.stall || busy_mask !== e.busy ||
                   outstanding !== e.outs || drain_ack !== e.ack) begin
        bad++;
        $display("FAIL %s: got stall=%0b busy=%h outs=%0d ack=%0b, want stall=%0b busy=%h outs=%0d ack=%0b",
                 e.name, stall_id, busy_mask, outstanding, drain_ack,
                 e.stall, e.busy, e.outs, e.ack);
      end
    end
  end

  initial begin
    idle_in();
    rst = 1;
    tick();
    // Reset overrides a same-cycle set
    iss_long(5'd3);
    chk("rst_comb", 0, 32'h0, 0, 0);
    tick();
    rst = 0; idle_in();
    chk("reset_state", 0, 32'h0, 0, 0);
    tick();

    // Load x5 then dependent add
    idle_in(); iss_long(5'd5);
    chk("load_x5", 0, 32'h0, 0, 0); tick();
    idle_in(); issue_valid = 1; uses_rs1 = 1; rs1_d = 5; wr_en_d = 1; rd_d = 8;
    chk("raw_stall_1", 1, 32'h20, 1, 0); tick();
    chk("raw_stall_2", 1, 32'h20, 1, 0); tick();
    wb(5'd5);
    chk("raw_wb_release", 0, 32'h20, 1, 0); tick();
    idle_in();
    chk("raw_cleared", 0, 32'h0, 0, 0); tick();

    // Fill to MAX_OUTSTANDING, then full stall released by same-cycle retire
    iss_long(5'd1); chk("fill_1", 0, 32'h0, 0, 0); tick();
    iss_long(5'd2); chk("fill_2", 0, 32'h2, 1, 0); tick();
    iss_long(5'd3); chk("fill_3", 0, 32'h6, 2, 0); tick();
    iss_long(5'd4); chk("fill_4", 0, 32'hE, 3, 0); tick();
    iss_long(5'd6); chk("full_stall", 1, 32'h1E, 4, 0); tick();
    wb(5'd2);       chk("full_retire", 0, 32'h1E, 4, 0); tick();
    idle_in(); wb(5'd1); chk("full_swap", 0, 32'h5A, 4, 0); tick();
    wb(5'd3); chk("ret_1", 0, 32'h58, 3, 0); tick();
    wb(5'd4); chk("ret_3", 0, 32'h50, 2, 0); tick();
    wb(5'd6); chk("ret_4", 0, 32'h40, 1, 0); tick();
    idle_in(); chk("ret_all", 0, 32'h0, 0, 0); tick();

    // x0 destination and flushed issue never set bits
    iss_long(5'd0); chk("x0_issue", 0, 32'h0, 0, 0); tick();
    idle_in(); iss_long(5'd7); flush_exe = 1;
    chk("flush_issue", 0, 32'h0, 0, 0); tick();
    idle_in(); chk("x0_flush_none", 0, 32'h0, 0, 0); tick();

    // Same-cycle set and clear of x9; bogus retires
    iss_long(5'd9); chk("x9_first", 0, 32'h0, 0, 0); tick();
    iss_long(5'd9); wb(5'd9); chk("x9_set_clr", 0, 32'h200, 1, 0); tick();
    idle_in(); wb(5'd10); chk("x9_set_wins", 0, 32'h200, 1, 0); tick();
    idle_in(); wb(5'd0); chk("wb_nonbusy", 0, 32'h200, 1, 0); tick();
    idle_in(); iss_long(5'd9); chk("waw_stall", 1, 32'h200, 1, 0); tick();
    idle_in(); issue_valid = 1; uses_rs2 = 1; rs2_d = 9;
    chk("raw_rs2", 1, 32'h200, 1, 0); tick();
    issue_valid = 0; chk("stall_gated", 0, 32'h200, 1, 0); tick();
    idle_in(); issue_valid = 1; uses_rs1 = 1; rs1_d = 0; uses_rs2 = 1; rs2_d = 10;
    chk("no_raw_x0", 0, 32'h200, 1, 0); tick();
    idle_in(); wb(5'd9); chk("x9_ret", 0, 32'h200, 1, 0); tick();
    idle_in(); chk("x9_gone", 0, 32'h0, 0, 0); tick();

    // Drain with two outstanding ops
    iss_long(5'd11); chk("dr_iss11", 0, 32'h0, 0, 0); tick();
    iss_long(5'd12); chk("dr_iss12", 0, 32'h800, 1, 0); tick();
    idle_in(); drain_req = 1; chk("dr_req", 0, 32'h1800, 2, 0); tick();
    idle_in(); issue_valid = 1; chk("dr_stall", 1, 32'h1800, 2, 0); tick();
    wb(5'd11); chk("dr_wb11", 1, 32'h1800, 2, 0); tick();
    wb(5'd12); chk("dr_wb12", 1, 32'h1000, 1, 0); tick();
    wb_done = 0; drain_req = 1; chk("dr_zero", 1, 32'h0, 0, 0); tick();
    chk("dr_ack", 1, 32'h0, 0, 1); tick();
    drain_req = 0; chk("dr_idle", 0, 32'h0, 0, 0); tick();
    idle_in(); chk("dr_after", 0, 32'h0, 0, 0); tick();

    // Reset in the middle of a drain
    iss_long(5'd13); chk("rd_iss13", 0, 32'h0, 0, 0); tick();
    iss_long(5'd14); chk("rd_iss14", 0, 32'h2000, 1, 0); tick();
    idle_in(); drain_req = 1; chk("rd_req", 0, 32'h6000, 2, 0); tick();
    idle_in(); rst = 1; wb(5'd13); chk("rd_in_drain", 0, 32'h6000, 2, 0); tick();
    rst = 0; idle_in(); issue_valid = 1;
    chk("rd_cleared", 0, 32'h0, 0, 0); tick();
    idle_in(); chk("rd_no_ack_1", 0, 32'h0, 0, 0); tick();
    chk("rd_no_ack_2", 0, 32'h0, 0, 0); tick();

    stim_done = 1'b1;
  end

  initial begin
    fork
      wait (stim_done);
      #100000;
    join_any
    disable fork;
    if (!stim_done) begin
      total++; bad++;
      $display("FAIL watchdog: stimulus did not complete, required completion");
    end
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover: %0d expectations unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
